// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - host-side valid/ready byte handshake into the UART transmitter
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start bit, 4-8 data bits LSB first, 1 or 2 stop bits
module uart_tx #(
  parameter int CLK_HZ       = 10_000_000,
  parameter int TX_CNT_WIDTH = $clog2(CLK_HZ / 115200) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [TX_CNT_WIDTH-1:0] clks_per_bit,
  input  logic [2:0]              bit_count_sel,
  input  logic                    stop_bits_sel,
  uart_tx_if.slave                tx_if,
  output logic                    tx,
  output logic                    busy,
  output logic                    tx_done
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  localparam logic [TX_CNT_WIDTH-1:0] CNT_ONE = 1;

  state_e                  state_q, state_d;
  logic [TX_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [TX_CNT_WIDTH-1:0] period_q, period_d;
  logic [7:0]              shift_q, shift_d;
  logic [3:0]              nbits_q, nbits_d;
  logic [3:0]              bit_idx_q, bit_idx_d;
  logic                    stop2_q, stop2_d;
  logic                    stop_idx_q, stop_idx_d;
  logic                    tx_q, tx_d;
  logic                    done_q, done_d;
  logic                    accept;
  logic                    bit_end;

  assign tx_if.tx_ready = (state_q == S_IDLE) && enable && !rst;
  assign accept         = tx_if.tx_valid && tx_if.tx_ready;
  assign bit_end        = (cnt_q == (period_q - CNT_ONE));

  assign tx      = tx_q;
  assign busy    = (state_q != S_IDLE);
  assign tx_done = done_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    shift_d    = shift_q;
    nbits_d    = nbits_q;
    bit_idx_d  = bit_idx_q;
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;
    tx_d       = tx_q;
    done_d     = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_ONE;
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          // Frame parameters are frozen here so mid-frame input changes are ignored.
          shift_d    = tx_if.tx_data;
          period_d   = (clks_per_bit == '0) ? CNT_ONE : clks_per_bit;
          nbits_d    = (bit_count_sel >= 3'd4) ? 4'd8 : {1'b0, bit_count_sel} + 4'd4;
          stop2_d    = stop_bits_sel;
          stop_idx_d = 1'b0;
          bit_idx_d  = 4'd0;
          cnt_d      = '0;
          tx_d       = 1'b0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = 4'd0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == (nbits_q - 4'd1)) begin
            tx_d       = 1'b1;
            stop_idx_d = 1'b0;
            state_d    = S_STOP;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      period_q   <= CNT_ONE;
      shift_q    <= '0;
      nbits_q    <= 4'd8;
      bit_idx_q  <= '0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      shift_q    <= shift_d;
      nbits_q    <= nbits_d;
      bit_idx_q  <= bit_idx_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx: spec vectors, corner sequences, random frames
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] clks_per_bit;
  logic [2:0] bit_count_sel;
  logic       stop_bits_sel;
  logic       tx;
  logic       busy;
  logic       tx_done;

  uart_tx_if u_if ();

  uart_tx dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .clks_per_bit  (clks_per_bit),
    .bit_count_sel (bit_count_sel),
    .stop_bits_sel (stop_bits_sel),
    .tx_if         (u_if),
    .tx            (tx),
    .busy          (busy),
    .tx_done       (tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] data;
    int         cpb;
    int         sel;
    int         stop;
    string      exp_bits;
    int         exp_len;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  logic got_q[$];
  logic exp_q[$];
  vec_t vecs[6];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference frame: P copies of each line level, computed straight from the frame format.
  function automatic void build_model(input logic [7:0] d, input int cpb, input int sel, input int stop);
    int p = (cpb == 0) ? 1 : cpb;
    int n = (sel >= 4) ? 8 : sel + 4;
    exp_q.delete();
    for (int k = 0; k < p; k++) exp_q.push_back(1'b0);
    for (int b = 0; b < n; b++)
      for (int k = 0; k < p; k++) exp_q.push_back(d[b]);
    for (int k = 0; k < (stop + 1) * p; k++) exp_q.push_back(1'b1);
  endfunction

  function automatic void build_from_string(input string s, input int cpb);
    int p = (cpb == 0) ? 1 : cpb;
    exp_q.delete();
    for (int i = 0; i < s.len(); i++)
      for (int k = 0; k < p; k++) exp_q.push_back(s[i] == 8'h31);
  endfunction

  // Called at a falling edge; returns at the falling edge just after the accept edge.
  task automatic send(input string name, input logic [7:0] d, input int cpb, input int sel,
                      input int stop, input bit keep_valid);
    int w = 0;
    u_if.tx_data   = d;
    u_if.tx_valid  = 1'b1;
    clks_per_bit   = cpb[7:0];
    bit_count_sel  = sel[2:0];
    stop_bits_sel  = stop[0];
    while (!u_if.tx_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w == 100) check({name, "_accept_timeout"}, 0, 1);
    @(negedge clk);
    u_if.tx_valid = keep_valid;
  endtask

  task automatic capture(input int poke_at);
    int n = 0;
    got_q.delete();
    while (busy && n < 5000) begin
      got_q.push_back(tx);
      if (n == poke_at) begin
        enable        = 1'b0;
        clks_per_bit  = 8'd7;
        bit_count_sel = 3'd0;
        stop_bits_sel = 1'b1;
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic compare(input string name);
    int first_bad = -1;
    check({name, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i] && first_bad < 0) first_bad = i;
    check({name, "_first_bad_bit_cycle"}, first_bad, -1);
    check({name, "_done_pulse"}, tx_done, 1);
    check({name, "_idle_tx"}, tx, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"basic8",   8'hA5, 4, 4, 0, "0101001011",  40};
    vecs[1] = '{"short5s2", 8'h13, 3, 1, 1, "01100111",    24};
    vecs[2] = '{"cpb0",     8'h01, 0, 4, 0, "0100000001",  10};
    vecs[3] = '{"cpb1",     8'h01, 1, 4, 0, "0100000001",  10};
    vecs[4] = '{"nib4",     8'hF0, 2, 0, 0, "000001",      12};
    vecs[5] = '{"sel7s2",   8'h5A, 1, 7, 1, "00101101011", 11};

    rst           = 1'b1;
    enable        = 1'b1;
    clks_per_bit  = 8'd4;
    bit_count_sel = 3'd4;
    stop_bits_sel = 1'b0;
    u_if.tx_data  = 8'h00;
    u_if.tx_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_done", tx_done, 0);
    check("reset_ready", u_if.tx_ready, 0);
    u_if.tx_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", u_if.tx_ready, 1);

    foreach (vecs[i]) begin
      send(vecs[i].name, vecs[i].data, vecs[i].cpb, vecs[i].sel, vecs[i].stop, 1'b0);
      capture(-1);
      check({vecs[i].name, "_spec_len"}, got_q.size(), vecs[i].exp_len);
      build_from_string(vecs[i].exp_bits, vecs[i].cpb);
      compare(vecs[i].name);
      @(negedge clk);
    end

    // Back-to-back: valid held high, second byte presented while the first is in flight.
    send("b2b0", 8'h00, 2, 4, 0, 1'b1);
    u_if.tx_data = 8'hFF;
    capture(-1);
    build_model(8'h00, 2, 4, 0);
    compare("b2b0");
    check("b2b_ready_on_done", u_if.tx_ready, 1);
    @(negedge clk);
    u_if.tx_valid = 1'b0;
    capture(-1);
    build_model(8'hFF, 2, 4, 0);
    compare("b2b1");
    @(negedge clk);

    // Mid-frame input changes and enable drop must not disturb the frame in flight.
    send("midchg", 8'hC3, 3, 4, 0, 1'b0);
    capture(10);
    build_model(8'hC3, 3, 4, 0);
    compare("midchg");
    check("midchg_ready_disabled", u_if.tx_ready, 0);
    u_if.tx_valid = 1'b1;
    repeat (4) @(negedge clk);
    check("midchg_no_accept", busy, 0);
    u_if.tx_valid = 1'b0;
    enable = 1'b1;
    #1;
    check("midchg_ready_reenabled", u_if.tx_ready, 1);
    @(negedge clk);

    // Reset during data bit 3 (P=2: start at cycles 1-2, bit3 begins at cycle 9).
    send("rstmid", 8'h00, 2, 4, 0, 1'b0);
    repeat (8) @(negedge clk);
    check("rstmid_pre_tx", tx, 0);
    rst = 1'b1;
    #1;
    check("rstmid_ready_in_rst", u_if.tx_ready, 0);
    @(negedge clk);
    check("rstmid_tx", tx, 1);
    check("rstmid_busy", busy, 0);
    check("rstmid_done", tx_done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_done_after", tx_done, 0);
    send("after_rst", 8'h5A, 2, 4, 0, 1'b0);
    capture(-1);
    build_model(8'h5A, 2, 4, 0);
    compare("after_rst");
    @(negedge clk);

    for (int r = 0; r < 20; r++) begin
      logic [7:0] d;
      int cpb, sel, stop;
      d    = 8'($urandom);
      cpb  = $urandom_range(0, 5);
      sel  = $urandom_range(0, 7);
      stop = $urandom_range(0, 1);
      send("rand", d, cpb, sel, stop, 1'b0);
      capture(-1);
      build_model(d, cpb, sel, stop);
      compare($sformatf("rand%0d", r));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: serialises one parallel byte per frame onto `tx`. A frame is one start bit, 4–8 data bits sent LSB first, no parity, and 1 or 2 stop bits. Bit period, data width and stop-bit count are runtime inputs, with the same encoding the UART receiver uses. The block sits between the host-side TX path (register interface or FIFO, via a valid/ready handshake) and the serial pin.

## Interface
- `CLK_HZ`, default 10_000_000: system clock frequency in Hz.
- `TX_CNT_WIDTH`, default `$clog2(CLK_HZ/115200)+1`: width of `clks_per_bit` and of the bit-period counter.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  when low, no new frame is accepted; a frame already in flight completes.
- `clks_per_bit`  in  TX_CNT_WIDTH  clock cycles per serial bit. A value of 0 is treated as 1.
- `bit_count_sel`  in  3  data bits = `bit_count_sel`+4, so 0→4 bits … 4→8 bits. Values 5–7 give 8 bits.
- `stop_bits_sel`  in  1  0 = one stop bit, 1 = two stop bits.
- `tx_data`  in  8  byte to send; only the low N bits are transmitted.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  block can accept a frame.
- `tx`  out  1  serial line; idles high; registered.
- `busy`  out  1  high from the cycle after acceptance through the last stop-bit cycle.
- `tx_done`  out  1  one-cycle pulse when a frame finishes.

## Operation
- States: IDLE → START → DATA → STOP → IDLE. Any unused encoding goes to IDLE.
- `tx_ready` = (state==IDLE) & `enable` & !`rst`. It is combinational and has no dependency on `tx_valid`.
- **Accept.** A frame is accepted on a clock edge where `tx_valid` & `tx_ready`. On that edge the block latches:
  - `tx_data` into a shift register;
  - the effective bit period (`clks_per_bit`, with 0 mapped to 1);
  - the data-bit count N;
  - the stop-bit count.
  Changes to these inputs mid-frame have no effect.
- **START.** `tx`=0 for one bit period.
- **DATA.** N bits, LSB first, each held one bit period. The bit index counts 0..N-1; after bit N-1 the FSM goes to STOP.
- **STOP.** `tx`=1 for 1 or 2 bit periods. After the final stop-bit cycle the FSM returns to IDLE and `tx_done`=1 for exactly that first IDLE cycle.
- **Bit-period counter.** Counts 0..P-1, where P is the latched period. The counter clears on each bit boundary and on acceptance. Counter arithmetic is TX_CNT_WIDTH wide; P-1 never underflows because P≥1.
- **`enable`.** Deasserting `enable` mid-frame does not abort the frame. It only blocks the next acceptance.
- **Reset.** `rst` at any time, including mid-frame, forces IDLE on the next edge with:
  - `tx`=1, `busy`=0, `tx_done`=0;
  - counters and shift register cleared.
  A truncated frame is not completed or flagged. While `rst` is high, `tx_ready`=0.

## Timing
- Reset values: `tx`=1, `tx_ready`=0 while `rst` is high, `busy`=0, `tx_done`=0.
- Acceptance at edge E: `tx` falls and `busy` rises in the cycle following E.
- Frame length is (1+N+S)·P cycles of `busy`=1, where S is the number of stop bits.
- `tx_done` and `tx_ready` rise together in the cycle after the last stop-bit cycle.
- Back-to-back frames:
  - `tx_valid` held high means the next frame is accepted on the first IDLE edge.
  - This gives exactly one `tx`=1 idle cycle between the last stop bit and the next start bit.
- `tx` changes only on bit boundaries and never glitches within a bit period.

## Test plan
- **Basic 8-bit frame.** P=4, sel=4, stop=0, `tx_data`=0xA5. Expect `tx` = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, for 40 cycles of `busy`. `tx_done` pulses 41 cycles after the accept edge.
- **Short frame, two stop bits.** P=3, sel=1 (5 bits), stop=1, data 0x13. Expect `tx` = 0,1,1,0,0,1,1,1, each 3 cycles, for 24 cycles. Upper data bits are ignored.
- **Back-to-back.** P=2, `tx_valid` held high with 0x00 then 0xFF. Expect two frames separated by exactly one high idle cycle and two `tx_done` pulses.
- **Mid-frame changes.** Change `clks_per_bit`/`bit_count_sel` and drop `enable` during DATA. The current frame is unchanged. No new acceptance happens while `enable`=0; after re-enable, `tx_ready`=1.
- **Reset mid-frame.** Assert `rst` in DATA bit 3. The next cycle shows `tx`=1, `busy`=0, no `tx_done`. After release, a new 0x5A frame transmits correctly.
- **Degenerate period.** `clks_per_bit`=0, then 1. Both give one cycle per bit; a frame of 0x01 at sel=4 lasts 10 cycles.
